// File: rtl/cpu_pkg.sv
// Shared constants for the five-stage pipeline: default widths, the NOP filler
// and the opcode encodings (HLT included) decoded downstream of fetch.
package cpu_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 16;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_LD  = 4'h8,
        OP_ST  = 4'h9,
        OP_JMP = 4'hC,
        OP_BEQ = 4'hD,
        OP_HLT = 4'hF
    } opcode_t;

    localparam logic [15:0] HLT_INSTR = {OP_HLT, 12'h000};

endpackage

// File: rtl/iq_fifo.sv
// Generic synchronous FIFO with flush; head entry is read straight from storage,
// so data_o is valid whenever count_o is non-zero.
module iq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (cnt_q != CW'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
        end
        if (do_pop) begin
            rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible below the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: credit-limited in-order requests to instruction
// memory, a small return queue, and redirect/stall/halt handling for IF/ID.
module ifetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req_valid,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_req_ready,
    input  logic          imem_rsp_valid,
    input  logic [DW-1:0] imem_rsp_data,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          stall,
    input  logic          hlt,
    output logic          instr_valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] pc_plus_1
);

    localparam int unsigned EW  = DW + AW;
    localparam int unsigned QCW = $clog2(DEPTH + 1);
    localparam int unsigned OW  = $clog2(MAX_OUT + 1);

    logic [AW-1:0]  fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]  drop_q, drop_d;
    logic [OW-1:0]  out_cnt;
    logic [QCW-1:0] q_cnt;
    logic [AW-1:0]  issued_pc1;
    logic [EW-1:0]  q_head;
    logic           req_acc, rsp_ok, q_push, q_pop;
    logic [31:0]    out_next;

    // Outstanding count is the occupancy of the issued-address FIFO.
    iq_fifo #(.DEPTH(MAX_OUT), .WIDTH(AW)) u_issued (
        .clk     (clk),
        .rst     (rst),
        .flush_i (1'b0),
        .push_i  (req_acc),
        .pop_i   (rsp_ok),
        .data_i  (fetch_pc_q + AW'(1)),
        .data_o  (issued_pc1),
        .count_o (out_cnt)
    );

    iq_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_instq (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .data_i  ({imem_rsp_data, issued_pc1}),
        .data_o  (q_head),
        .count_o (q_cnt)
    );

    // Credit check ignores a same-cycle pop, so a response never meets a full queue.
    assign imem_req_valid = !rst && !hlt && !redirect
                         && ((32'(q_cnt) + 32'(out_cnt)) < DEPTH)
                         && (32'(out_cnt) < MAX_OUT);
    assign imem_req_addr  = fetch_pc_q;

    assign req_acc = imem_req_valid && imem_req_ready;
    assign rsp_ok  = imem_rsp_valid && (out_cnt != '0);
    assign q_push  = rsp_ok && (drop_q == '0) && !redirect;
    assign q_pop   = instr_valid && !stall && !redirect;

    assign out_next = 32'(out_cnt) + 32'(req_acc) - 32'(rsp_ok);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            // Every request still in flight after this edge belongs to the old stream.
            drop_d     = (out_next > MAX_OUT) ? OW'(MAX_OUT) : OW'(out_next);
        end else begin
            if (req_acc) begin
                fetch_pc_d = fetch_pc_q + AW'(1);
            end
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - OW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

    assign instr_valid = (q_cnt != '0);
    assign instr       = instr_valid ? q_head[EW-1:AW] : DW'(NOP_INSTR);
    assign pc_plus_1   = instr_valid ? q_head[AW-1:0] : '0;

endmodule
